// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider (SDIV/UDIV): one quotient bit per cycle through a
// DATA_WIDTH+1 subtractor. Optional early-out when |divisor| > |dividend|: DIV_EARLY_OUT_EN.
module div_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  // The partial remainder is always below the divisor, so DATA_WIDTH bits hold it;
  // only the shifted value fed to the subtractor needs the extra bit.
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  dbz_q, dbz_d;
  logic [DATA_WIDTH-1:0] quo_out_q, quo_out_d;
  logic [DATA_WIDTH-1:0] rem_out_q, rem_out_d;

  // Operand magnitudes
  logic                  dvd_neg, dvs_neg;
  logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;

  assign dvd_neg = is_signed & dividend[DATA_WIDTH-1];
  assign dvs_neg = is_signed & divisor[DATA_WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // Subtract-mode adder: carry_out == 1 means no borrow
  logic [DATA_WIDTH:0] add_a, add_b, add_sum;
  logic                add_cout;
  logic                unused_sum_msb;

  assign add_a = {rem_q, dvd_q[DATA_WIDTH-1]};
  assign add_b = {1'b0, dvs_q};
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, ~add_b} + (DATA_WIDTH + 2)'(1);
  assign unused_sum_msb = add_sum[DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dbz_d     = dbz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          rem_d   = '0;
          cnt_d   = CNT_WIDTH'(DATA_WIDTH);
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            dbz_d     = 1'b1;
            quo_out_d = '0;
            rem_out_d = dividend;
            state_d   = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        if (add_cout) begin
          rem_d = add_sum[DATA_WIDTH-1:0];
          dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = add_a[DATA_WIDTH-1:0];
          dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = StFix;
        end
`ifdef DIV_EARLY_OUT_EN
        // First step still sees the untouched magnitudes; a larger divisor means q = 0.
        if (cnt_q == CNT_WIDTH'(DATA_WIDTH) && dvs_q > dvd_q) begin
          rem_d   = dvd_q;
          dvd_d   = '0;
          cnt_d   = '0;
          state_d = StFix;
        end
`endif
      end

      StFix: begin
        quo_out_d = q_neg_q ? -dvd_q : dvd_q;
        rem_out_d = r_neg_q ? -rem_q : rem_q;
        state_d   = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dbz_q     <= dbz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed/unsigned results,
// divide-by-zero, overflow, ignored start and mid-operation reset.
`timescale 1us/1ns
module tb_div_sequencer;
  localparam int unsigned W       = 64;
  localparam int          Timeout = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int lat, busy_bad, extra_done, dones;

  div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one divide (start sampled at edge 0), return the cycle done appears in.
  // A stray start is pulsed during cycle `stray` when stray > 0.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stray, output int lat_o, output int busy_bad_o,
                         output int extra_o);
    int post;
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    lat_o      = -1;
    busy_bad_o = 0;
    extra_o    = 0;
    for (int c = 1; c <= Timeout; c++) begin
      if (done) begin
        lat_o = c;
        if (busy !== 1'b0) busy_bad_o++;
        break;
      end
      if (busy !== 1'b1) busy_bad_o++;
      if (stray > 0 && c == stray) begin
        start    = 1'b1;
        dividend = 64'd5;
        divisor  = 64'd1;
      end else if (stray > 0 && c == stray + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    post = (stray > 0) ? 70 : 1;
    for (int i = 0; i < post; i++) begin
      @(negedge clk);
      if (done) extra_o++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    run_div(1'b0, 64'd100, 64'd7, 10, lat, busy_bad, extra_done);
    check("u100_7_quot", quotient, 64'd14);
    check("u100_7_rem", remainder, 64'd2);
    check("u100_7_dbz", div_by_zero, 0);
    check("u100_7_lat", lat, 66);
    check("u100_7_busy", busy_bad, 0);
    check("u100_7_stray_done", extra_done, 0);

    run_div(1'b1, -64'sd7, 64'd2, 0, lat, busy_bad, extra_done);
    check("sm7_2_quot", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    check("sm7_2_rem", remainder, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sm7_2_lat", lat, 66);
    check("sm7_2_pulse", extra_done, 0);

    run_div(1'b1, 64'd7, -64'sd2, 0, lat, busy_bad, extra_done);
    check("s7_m2_quot", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    check("s7_m2_rem", remainder, 64'd1);

    run_div(1'b1, -64'sd100, 64'd7, 0, lat, busy_bad, extra_done);
    check("sm100_7_quot", quotient, -64'sd14);
    check("sm100_7_rem", remainder, -64'sd2);

    run_div(1'b0, 64'h1234, 64'd0, 0, lat, busy_bad, extra_done);
    check("dbz_quot", quotient, 64'd0);
    check("dbz_rem", remainder, 64'h1234);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_lat", lat, 1);

    run_div(1'b0, 64'd9, 64'd3, 0, lat, busy_bad, extra_done);
    check("u9_3_quot", quotient, 64'd3);
    check("u9_3_rem", remainder, 64'd0);
    check("u9_3_dbz", div_by_zero, 0);
    check("u9_3_lat", lat, 66);

    run_div(1'b1, 64'h8000_0000_0000_0000, -64'sd1, 0, lat, busy_bad, extra_done);
    check("smin_m1_quot", quotient, 64'h8000_0000_0000_0000);
    check("smin_m1_rem", remainder, 64'd0);
    check("smin_m1_dbz", div_by_zero, 0);

    run_div(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, lat, busy_bad, extra_done);
    check("umax_1_quot", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("umax_1_rem", remainder, 64'd0);

    // Reset in cycle 30 of a 100/7 divide
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 64'd100;
    divisor   = 64'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quot", quotient, 0);
    check("midrst_rem", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run_div(1'b0, 64'd50, 64'd5, 0, lat, busy_bad, extra_done);
    check("u50_5_quot", quotient, 64'd10);
    check("u50_5_rem", remainder, 64'd0);
    check("u50_5_lat", lat, 66);

    run_div(1'b0, 64'd3, 64'd10, 0, lat, busy_bad, extra_done);
    check("u3_10_quot", quotient, 64'd0);
    check("u3_10_rem", remainder, 64'd3);
`ifdef DIV_EARLY_OUT_EN
    check("u3_10_lat", lat, 3);
`else
    check("u3_10_lat", lat, 66);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
